// File: rtl/led_fader.sv
// PWM LED fader: each channel's brightness ramps linearly toward its commanded
// on/off state, and the registered led outputs are PWM-modulated by that level.
module led_fader #(
    parameter int CHANNELS  = 4,
    parameter int PWM_BITS  = 8,
    parameter int STEP_LOG2 = 12
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic [CHANNELS-1:0]          target,
    output logic [CHANNELS-1:0]          led,
    output logic [CHANNELS*PWM_BITS-1:0] level,
    output logic                         settled
);

    // A zero-width prescaler is not legal; keep one dummy bit when STEP_LOG2 = 0.
    localparam int PRE_W = (STEP_LOG2 > 0) ? STEP_LOG2 : 1;
    localparam logic [PWM_BITS-1:0] MAX_LEVEL  = '1;
    localparam logic [PWM_BITS-1:0] ZERO_LEVEL = '0;

    logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
    logic [PRE_W-1:0]                   prescaler_q, prescaler_d;
    logic [CHANNELS-1:0]                t_q, t_d;
    logic [CHANNELS-1:0][PWM_BITS-1:0]  level_q, level_d;
    logic [CHANNELS-1:0]                led_q, led_d;
    logic                               settled_q, settled_d;
    logic                               tick_s;

    // Next-state logic for counters, ramps, PWM compare and the settled flag.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

        if (enable) begin
            prescaler_d = prescaler_q + PRE_W'(1);
        end else begin
            prescaler_d = prescaler_q;
        end

        if (STEP_LOG2 == 0) begin
            tick_s = 1'b1;
        end else begin
            tick_s = &prescaler_q;
        end

        t_d       = target;
        settled_d = 1'b1;
        led_d     = '0;
        level_d   = level_q;

        for (int i = 0; i < CHANNELS; i++) begin
            // Direction comes from the registered target, so a tick coinciding
            // with a target change still steps the old way.
            if (enable && tick_s) begin
                if (t_q[i] && (level_q[i] != MAX_LEVEL)) begin
                    level_d[i] = level_q[i] + PWM_BITS'(1);
                end else if (!t_q[i] && (level_q[i] != ZERO_LEVEL)) begin
                    level_d[i] = level_q[i] - PWM_BITS'(1);
                end else begin
                    level_d[i] = level_q[i];
                end
            end else begin
                level_d[i] = level_q[i];
            end

            // MAX is special-cased so full brightness never blinks off at pwm_cnt = MAX.
            led_d[i] = enable & ((level_q[i] == MAX_LEVEL) | (level_q[i] > pwm_cnt_q));

            settled_d = settled_d &
                        (t_q[i] ? (level_q[i] == MAX_LEVEL) : (level_q[i] == ZERO_LEVEL));
        end
    end

    // State registers; reset clears everything immediately, with no fade-out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt_q   <= '0;
            prescaler_q <= '0;
            t_q         <= '0;
            level_q     <= '0;
            led_q       <= '0;
            settled_q   <= 1'b1;
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            prescaler_q <= prescaler_d;
            t_q         <= t_d;
            level_q     <= level_d;
            led_q       <= led_d;
            settled_q   <= settled_d;
        end
    end

    assign led     = led_q;
    assign level   = level_q;
    assign settled = settled_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: directed vector table, hand sequences for
// disable/reset/PWM duty, and randomized traffic against a behavioural model.
module tb_led_fader;

    localparam int CH   = 4;
    localparam int PB   = 4;
    localparam int SL   = 2;
    localparam int P    = 1 << SL;
    localparam int MAXV = (1 << PB) - 1;

    logic            clk     = 1'b0;
    logic            resetn  = 1'b0;
    logic            enable  = 1'b1;
    logic [CH-1:0]   target  = 4'b0000;
    logic [CH-1:0]   led;
    logic [CH*PB-1:0] level;
    logic            settled;

    logic            resetn2 = 1'b0;
    logic            enable2 = 1'b1;
    logic [CH-1:0]   target2 = 4'b0001;
    logic [CH-1:0]   led2;
    logic [CH*PB-1:0] level2;
    logic            settled2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    led_fader #(.CHANNELS(CH), .PWM_BITS(PB), .STEP_LOG2(SL)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .target(target),
        .led(led), .level(level), .settled(settled)
    );

    // Slow-ramp instance so a brightness level holds long enough to measure duty.
    led_fader #(.CHANNELS(CH), .PWM_BITS(PB), .STEP_LOG2(8)) dut_slow (
        .clk(clk), .resetn(resetn2), .enable(enable2), .target(target2),
        .led(led2), .level(level2), .settled(settled2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts total and enabled cycles since reset; pwm phase
    // and tick timing follow from plain modulo arithmetic on those counts.
    typedef struct packed {
        int               cyc;
        int               en_cyc;
        logic [CH-1:0]    t;
        logic [CH-1:0][7:0] lvl;
        logic [CH-1:0]    led;
        logic             set;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r     = '0;
        r.set = 1'b1;
        return r;
    endfunction

    function automatic model_t model_step(model_t s, logic [CH-1:0] tgt, logic en);
        model_t n;
        bit     tick;
        n     = s;
        n.set = 1'b1;
        tick  = ((s.en_cyc % P) == (P - 1));
        for (int i = 0; i < CH; i++) begin
            n.led[i] = en && ((int'(s.lvl[i]) == MAXV) || (int'(s.lvl[i]) > (s.cyc % (1 << PB))));
            n.set    = n.set && (s.t[i] ? (int'(s.lvl[i]) == MAXV) : (int'(s.lvl[i]) == 0));
            if (en && tick) begin
                if (s.t[i] && int'(s.lvl[i]) < MAXV) n.lvl[i] = s.lvl[i] + 8'd1;
                else if (!s.t[i] && int'(s.lvl[i]) > 0) n.lvl[i] = s.lvl[i] - 8'd1;
            end
        end
        n.t      = tgt;
        n.cyc    = s.cyc + 1;
        n.en_cyc = s.en_cyc + (en ? 1 : 0);
        return n;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m <= model_reset();
        else         m <= model_step(m, target, enable);
    end

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < CH; i++)
                check($sformatf("model_level%0d", i), int'(level[i*PB +: PB]), int'(m.lvl[i]));
            check("model_led", int'(led), int'(m.led));
            check("model_settled", int'(settled), int'(m.set));
        end
    end

    typedef struct {
        logic [CH-1:0] tgt;
        logic          en;
        int            n;
        int            exp_l0;
        int            exp_set;
        int            exp_led0;   // -1 = not checked
    } vec_t;

    vec_t vt[13];

    initial begin
        int hi;
        int k;

        // Directed sequence from reset release: ramp up, reverse mid-ramp,
        // full ramp to MAX, ramp down to 10, disable hold, resume.
        vt[0]  = '{4'b0000, 1'b1, 100,  0, 1,  0};
        vt[1]  = '{4'b0001, 1'b1,   3,  0, 0, -1};
        vt[2]  = '{4'b0001, 1'b1,   1,  1, 0, -1};
        vt[3]  = '{4'b0001, 1'b1,  20,  6, 0, -1};
        vt[4]  = '{4'b0000, 1'b1,   1,  6, 0, -1};
        vt[5]  = '{4'b0000, 1'b1,   3,  5, 0, -1};
        vt[6]  = '{4'b0000, 1'b1,  21,  0, 1,  0};
        vt[7]  = '{4'b0001, 1'b1,  59, 15, 0, -1};
        vt[8]  = '{4'b0001, 1'b1,   1, 15, 1,  1};
        vt[9]  = '{4'b0000, 1'b1,  20, 10, 0, -1};
        vt[10] = '{4'b0000, 1'b0,  50, 10, 0,  0};
        vt[11] = '{4'b0000, 1'b1,   2, 10, 0, -1};
        vt[12] = '{4'b0000, 1'b1,   1,  9, 0, -1};

        repeat (3) @(negedge clk);
        check("reset_level", int'(level), 0);
        check("reset_led", int'(led), 0);
        check("reset_settled", int'(settled), 1);
        chk_en = 1'b1;
        resetn = 1'b1;

        for (int v = 0; v < 13; v++) begin
            target = vt[v].tgt;
            enable = vt[v].en;
            repeat (vt[v].n) @(negedge clk);
            check($sformatf("vec%0d_level0", v), int'(level[PB-1:0]), vt[v].exp_l0);
            check($sformatf("vec%0d_level_others", v), int'(level[CH*PB-1:PB]), 0);
            check($sformatf("vec%0d_settled", v), int'(settled), vt[v].exp_set);
            if (vt[v].exp_led0 >= 0)
                check($sformatf("vec%0d_led0", v), int'(led[0]), vt[v].exp_led0);
        end

        // Asynchronous reset between edges at level 12.
        target = 4'b0001;
        k = 0;
        while (k < 200 && level[PB-1:0] != 4'd12) begin
            @(negedge clk);
            k++;
        end
        check("reach_level12_timeout", int'(level[PB-1:0]), 12);
        #3 resetn = 1'b0;
        #1;
        check("async_rst_level", int'(level), 0);
        check("async_rst_led", int'(led), 0);
        check("async_rst_pwm_cnt", int'(dut.pwm_cnt_q), 0);
        check("async_rst_settled", int'(settled), 1);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("restart_level_hold", int'(level[PB-1:0]), 0);
        @(negedge clk);
        check("restart_first_step", int'(level[PB-1:0]), 1);

        // Randomized traffic, compared cycle by cycle against the model.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) target[$urandom_range(0, CH - 1)] ^= 1'b1;
            if ($urandom_range(0, 29) == 0) enable = ~enable;
        end
        enable = 1'b1;
        repeat (4) @(negedge clk);

        // PWM duty: level 8 of 15 must give 8 high cycles per 16-cycle window.
        resetn2 = 1'b1;
        k = 0;
        while (k < 3000 && level2[PB-1:0] != 4'd8) begin
            @(negedge clk);
            k++;
        end
        check("slow_reach_level8_timeout", int'(level2[PB-1:0]), 8);
        for (int w = 0; w < 4; w++) begin
            hi = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (led2[0]) hi++;
            end
            check($sformatf("duty_window%0d", w), hi, 8);
        end
        check("slow_level_held", int'(level2[PB-1:0]), 8);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
